mem_access_controller: RTL and testbench

Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register, over a request/ready handshake to a variable-latency data memory. While an access is outstanding it freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) and feeds bubbles into MEM/WB. On completion it releases the pipeline for exactly one cycle and presents load data to MEM/WB. Sits between the EX/MEM register outputs and the data memory, in the MEM stage.

---
 rtl/mem_access_controller.sv | 135 +++++++++++++
 tb/tb_mem_access_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// MEM-stage data-memory access sequencer: latches the EX/MEM access, drives a req/ready
// handshake, and stalls the pipeline until completion. Optional macro: MEM_TIMEOUT_EN.
module mem_access_controller #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              In_MemRead,
    input  logic              In_MemWrite,
    input  logic [DATA_W-1:0] In_Address,
    input  logic [DATA_W-1:0] In_Write_Data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] Read_Data,
    output logic              Stall,
    output logic              Bubble,
    output logic              Busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              access_req;

    assign access_req = In_MemRead | In_MemWrite;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (access_req) begin
                    state_d = StReq;
                    addr_d  = In_Address;
                    wdata_d = In_Write_Data;
                    // A simultaneous read+write is treated as a write.
                    we_d    = In_MemWrite;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StReq, StWait: begin
                if (mem_ready) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (state_q == StReq) begin
                    state_d = StWait;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntW'(TIMEOUT)) begin
                        state_d = StDone;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        Busy      = (state_q == StReq) || (state_q == StWait);
        mem_req   = Busy;
        // Combinational IDLE term: stall in the very cycle the access is detected.
        Stall     = ((state_q == StIdle) && access_req) || Busy;
        Bubble    = Stall;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        Read_Data = rdata_q;
`ifdef MEM_TIMEOUT_EN
        timeout_err = err_q;
`else
        timeout_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: transaction-level model compared every
// cycle, plus directed literal checks. Honours MEM_TIMEOUT_EN when defined.
module tb_mem_access_controller;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              In_MemRead, In_MemWrite;
    logic [DATA_W-1:0] In_Address, In_Write_Data;
    logic              mem_req, mem_we, mem_ready;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata, Read_Data;
    logic              Stall, Bubble, Busy, timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_delay = 0;
    logic [DATA_W-1:0] rdata_val = '0;
    int req_cnt = 0;
    int req_starts = 0;
    logic prev_req = 1'b0;

    mem_access_controller #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .In_MemRead(In_MemRead), .In_MemWrite(In_MemWrite),
        .In_Address(In_Address), .In_Write_Data(In_Write_Data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .Read_Data(Read_Data),
        .Stall(Stall), .Bubble(Bubble), .Busy(Busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: ready after ready_delay non-ready request cycles; noise when idle.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (!prev_req) req_starts++;
            mem_ready = (req_cnt == ready_delay);
            mem_rdata = mem_ready ? rdata_val : $urandom;
            req_cnt++;
        end else begin
            req_cnt   = 0;
            mem_ready = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
        end
        prev_req = mem_req;
    end

    // Transaction-level model: an access is either outstanding, just completed, or absent.
    logic              m_active, m_done, m_we, m_err;
    logic [DATA_W-1:0] m_addr, m_wdata, m_rd;
    int                m_missed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_we = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_rd = 0; m_missed = 0;
        end else if (m_active) begin
            if (mem_ready) begin
                m_active = 0;
                m_done   = 1;
                if (!m_we) m_rd = mem_rdata;
            end else begin
                m_missed++;
`ifdef MEM_TIMEOUT_EN
                // REQ cycle plus TIMEOUT wait cycles without a response.
                if (m_missed == TIMEOUT + 1) begin
                    m_active = 0; m_done = 1; m_rd = 0; m_err = 1;
                end
`endif
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (In_MemRead || In_MemWrite) begin
            m_active = 1;
            m_addr   = In_Address;
            m_wdata  = In_Write_Data;
            m_we     = In_MemWrite;
            m_missed = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_stall;
            exp_stall = m_active || (!m_done && (In_MemRead || In_MemWrite));
            check("mem_req", {31'b0, mem_req}, {31'b0, m_active});
            check("busy", {31'b0, Busy}, {31'b0, m_active});
            check("stall", {31'b0, Stall}, {31'b0, exp_stall});
            check("bubble", {31'b0, Bubble}, {31'b0, exp_stall});
            check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("read_data", Read_Data, m_rd);
            check("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
        end
    end

    int start_cyc, end_cyc;

    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                         output int stall_cyc, output int req_cyc);
        bit done;
        @(posedge clk);
        #1;
        ready_delay   = delay;
        rdata_val     = rdata;
        In_MemRead    = rd;
        In_MemWrite   = wr;
        In_Address    = addr;
        In_Write_Data = wdata;
        stall_cyc = 0;
        req_cyc   = 0;
        done      = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) start_cyc = cyc;
            if (Stall) stall_cyc++;
            if (mem_req) req_cyc++;
            if (!Stall) begin
                done    = 1;
                end_cyc = cyc;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_complete: got no completion expected DONE within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        In_MemRead    = 0;
        In_MemWrite   = 0;
        In_Address    = $urandom;
        In_Write_Data = $urandom;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int st, rq, first_start, starts0;
        rst_n = 0;
        In_MemRead = 0; In_MemWrite = 0; In_Address = 0; In_Write_Data = 0;
        mem_ready = 0; mem_rdata = 0;
        #12;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_stall", {31'b0, Stall}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_read_data", Read_Data, 32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        rst_n = 1;
        idle(2);

        // Zero-wait load.
        do_op(1, 0, 32'h40, 32'h0, 0, 32'hCAFEF00D, st, rq);
        check("load_stall_cycles", st, 2);
        check("load_read_data", Read_Data, 32'hCAFEF00D);
        check("load_addr", mem_addr, 32'h40);
        check("load_we", {31'b0, mem_we}, 32'd0);
        idle(3);

        // Store with three wait cycles.
        do_op(0, 1, 32'h80, 32'h12345678, 3, 32'h0, st, rq);
        check("store_req_cycles", rq, 4);
        check("store_stall_cycles", st, 5);
        check("store_we", {31'b0, mem_we}, 32'd1);
        check("store_wdata", mem_wdata, 32'h12345678);
        check("store_read_data_kept", Read_Data, 32'hCAFEF00D);
        idle(2);

        // Back-to-back load then store.
        starts0 = req_starts;
        do_op(1, 0, 32'h44, 32'h0, 0, 32'h0BADBEEF, st, rq);
        first_start = start_cyc;
        do_op(0, 1, 32'h48, 32'hA5A5A5A5, 0, 32'h0, st, rq);
        check("b2b_total_cycles", end_cyc - first_start + 1, 6);
        check("b2b_requests", req_starts - starts0, 2);
        check("b2b_read_data", Read_Data, 32'h0BADBEEF);
        idle(2);

        // Read and write together: behaves as a write.
        do_op(1, 1, 32'h4C, 32'h5555AAAA, 1, 32'hDEADDEAD, st, rq);
        check("rw_we", {31'b0, mem_we}, 32'd1);
        check("rw_read_data_kept", Read_Data, 32'h0BADBEEF);
        idle(2);

        // Asynchronous reset while waiting.
        @(posedge clk);
        #1;
        ready_delay = 50;
        In_MemRead = 1; In_Address = 32'h100;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {31'b0, Busy}, 32'd1);
        #2;
        rst_n = 0;
        In_MemRead = 0;
        #1;
        check("arst_mem_req", {31'b0, mem_req}, 32'd0);
        check("arst_stall", {31'b0, Stall}, 32'd0);
        check("arst_busy", {31'b0, Busy}, 32'd0);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_read_data", Read_Data, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_busy", {31'b0, Busy}, 32'd0);
        idle(1);

`ifdef MEM_TIMEOUT_EN
        do_op(1, 0, 32'h200, 32'h0, 1000, 32'h77777777, st, rq);
        check("to_stall_cycles", st, 17);
        check("to_read_data", Read_Data, 32'd0);
        check("to_err", {31'b0, timeout_err}, 32'd1);
`else
        do_op(1, 0, 32'h200, 32'h0, 20, 32'h77777777, st, rq);
        check("long_stall_cycles", st, 22);
        check("long_read_data", Read_Data, 32'h77777777);
        check("long_err", {31'b0, timeout_err}, 32'd0);
`endif
        idle(2);
        do_op(1, 0, 32'h204, 32'h0, 0, 32'h11112222, st, rq);
        check("after_read_data", Read_Data, 32'h11112222);
`ifdef MEM_TIMEOUT_EN
        check("after_err_sticky", {31'b0, timeout_err}, 32'd1);
`else
        check("after_err_zero", {31'b0, timeout_err}, 32'd0);
`endif
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
